// File: rtl/pattern_det_sched.sv
// Shared serial pattern detector: round-robin grants one channel's bit per cycle into one compare engine.
// Latency: match_o/match_ch_o registered, 1 cycle after the grant edge; MATCH_CNT_EN adds match_cnt_o.
// Backpressure: a bit is consumed only on req&gnt; ungranted requesters hold their bit and retry.
module pattern_det_sched #(
    parameter int              CH_W    = 2,
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1001
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en_i,
    input  logic [(1<<CH_W)-1:0]        req_i,
    input  logic [(1<<CH_W)-1:0]        data_i,
    output logic [(1<<CH_W)-1:0]        gnt_o,
    input  logic                        cfg_we_i,
    input  logic [PAT_W-1:0]            cfg_pat_i,
    input  logic [$clog2(PAT_W):0]      cfg_len_i,
    input  logic                        cfg_ovl_i,
    output logic                        match_o,
    output logic [CH_W-1:0]             match_ch_o,
    output logic                        busy_o
`ifdef MATCH_CNT_EN
    ,
    output logic [15:0]                 match_cnt_o
`endif
);

    localparam int NUM_CH = 1 << CH_W;
    localparam int LEN_W  = $clog2(PAT_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic             ovl;
    } cfg_t;

    state_t           state, state_nx;
    cfg_t             cfg_q;
    logic [CH_W-1:0]  rr_ptr;
    logic [PAT_W-1:0] hist [NUM_CH];
    logic [LEN_W-1:0] fill [NUM_CH];

    logic             run, clr;
    logic             gnt_vld;
    logic [CH_W-1:0]  gnt_idx;
    logic [LEN_W-1:0] len_in;
    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] h_new;
    logic [LEN_W-1:0] f_new;
    logic             hit;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (en_i) state_nx = S_CLEAR;
            S_CLEAR: state_nx = en_i ? S_RUN : S_IDLE;
            S_RUN: begin
                if (!en_i) begin
                    state_nx = S_IDLE;
                end else if (cfg_we_i) begin
                    state_nx = S_CLEAR;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        run    = (state == S_RUN);
        clr    = (state == S_CLEAR);
        busy_o = run | clr;
    end

    // ---------------- Arbiter ----------------
    always_comb begin
        logic [CH_W-1:0] cand;
        cand    = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (run) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cand = rr_ptr + CH_W'(i);
                if (!gnt_vld && req_i[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (gnt_vld) begin
            gnt_o[gnt_idx] = 1'b1;
        end
    end

    // ---------------- Compare engine ----------------
    // Out-of-range lengths fall back to the full pattern width.
    always_comb begin
        len_in = cfg_len_i;
        if (cfg_len_i == '0 || cfg_len_i > LEN_W'(PAT_W)) begin
            len_in = LEN_W'(PAT_W);
        end
    end

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(cfg_q.len)) begin
                len_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        h_new = {hist[gnt_idx][PAT_W-2:0], data_i[gnt_idx]};
        f_new = (fill[gnt_idx] >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill[gnt_idx] + LEN_W'(1);
        hit   = gnt_vld && (f_new >= cfg_q.len) && (((h_new ^ cfg_q.pat) & len_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cfg_q      <= {PAT_RST, LEN_W'(PAT_W), 1'b1};
            rr_ptr     <= '0;
            match_o    <= 1'b0;
            match_ch_o <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
            end
        end else begin
            if (cfg_we_i) begin
                cfg_q <= {cfg_pat_i, len_in, cfg_ovl_i};
            end
            match_o <= hit;
            if (gnt_vld) begin
                rr_ptr        <= gnt_idx + CH_W'(1);
                match_ch_o    <= gnt_idx;
                hist[gnt_idx] <= h_new;
                fill[gnt_idx] <= (hit && !cfg_q.ovl) ? '0 : f_new;
            end
            // History bits survive CLEAR; zero fill alone makes them unmatchable.
            if (clr) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    fill[i] <= '0;
                end
            end
        end
    end

`ifdef MATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn || cfg_we_i) begin
            match_cnt_o <= '0;
        end else if (match_o && match_cnt_o != 16'hFFFF) begin
            match_cnt_o <= match_cnt_o + 16'd1;
        end
    end
`endif

endmodule
